// File: rtl/boot_pkg.sv
// Shared constants for the UART boot loader: start byte, protocol FSM encoding,
// byte-index width and the running checksum helper.
package boot_pkg;

  localparam logic [7:0] START_BYTE = 8'hA5;
  localparam int         BYTE_IDX_W = 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_LEN0 = S_LEN0,
    ST_LEN1 = S_LEN1,
    ST_DATA = S_DATA,
    ST_CSUM = S_CSUM,
    ST_DONE = S_DONE,
    ST_ERR  = S_ERR
  } boot_state_e;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_boot_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, one-cycle byte_valid
// or frame_err pulse after the stop-bit sample.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  rx_state_e        state_r, state_nx;
  logic [2:0]       sync_r;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [2:0]       bit_r, bit_nx;
  logic [7:0]       shift_r, shift_nx;
  logic [7:0]       data_r, data_nx;
  logic             valid_r, valid_nx;
  logic             ferr_r, ferr_nx;
  logic             rx_s, fall_s;

  // sync_r[1] is the synchronised line, sync_r[2] its previous value
  assign rx_s   = sync_r[1];
  assign fall_s = sync_r[2] & ~sync_r[1];

  // Synchroniser and receiver state registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_r  <= 3'b111;
      state_r <= RX_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[1:0], rxd};
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      bit_r   <= bit_nx;
      shift_r <= shift_nx;
      data_r  <= data_nx;
      valid_r <= valid_nx;
      ferr_r  <= ferr_nx;
    end
  end

  // Bit timing and framing
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    bit_nx   = bit_r;
    shift_nx = shift_r;
    data_nx  = data_r;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_nx = {CNT_W{1'b0}};
        bit_nx = 3'd0;
        if (fall_s) state_nx = RX_START;
        else        state_nx = RX_IDLE;
      end
      RX_START: begin
        if (cnt_r == HALF_M1) begin
          cnt_nx = {CNT_W{1'b0}};
          // a start bit that is high again at mid-bit was a glitch
          if (!rx_s) state_nx = RX_DATA;
          else       state_nx = RX_IDLE;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_nx   = {CNT_W{1'b0}};
          shift_nx = {rx_s, shift_r[7:1]};
          bit_nx   = bit_r + 3'd1;
          if (bit_r == 3'd7) state_nx = RX_STOP;
          else               state_nx = RX_DATA;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_nx   = {CNT_W{1'b0}};
          state_nx = RX_IDLE;
          if (rx_s) begin
            valid_nx = 1'b1;
            data_nx  = shift_r;
          end else begin
            ferr_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_r;
  assign byte_data  = data_r;
  assign frame_err  = ferr_r;

endmodule

// File: rtl/uart_boot_loader.sv
// Serial image loader: parses A5|LEN|words[|CSUM] frames from UART and writes memory.
// Optional trailing XOR checksum enabled by defining BOOT_CHECKSUM_EN.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          MAX_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rxd,
  output logic        wmem,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        err,
  output logic        cpu_run
);

  localparam int          WIDX_W  = $clog2(MAX_WORDS + 1);
  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e ST_TAIL = ST_CSUM;
`else
  localparam boot_state_e ST_TAIL = ST_DONE;
`endif

  logic                  byte_valid, frame_err;
  logic [7:0]            byte_data;
  boot_state_e           state_r, state_nx;
  logic [7:0]            len_lo_r, len_lo_nx;
  logic [15:0]           len_r, len_nx, len_s;
  logic [BYTE_IDX_W-1:0] byte_idx_r, byte_idx_nx;
  logic [WIDX_W-1:0]     word_idx_r, word_idx_nx, word_idx_inc_s;
  logic [31:0]           wdata_r, wdata_nx, addr_r, addr_nx;
  logic                  wmem_r, wmem_nx, busy_r, busy_nx;
  logic                  err_r, err_nx, cpu_run_r, cpu_run_nx;
  logic                  start_s;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .resetn    (resetn),
    .rxd       (rxd),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign start_s        = byte_valid && (byte_data == START_BYTE);
  assign len_s          = {byte_data, len_lo_r};
  assign word_idx_inc_s = word_idx_r + WIDX_W'(1);

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum_r;

  // XOR of every data byte since the last accepted start byte
  always_ff @(posedge clk) begin
    if (!resetn) begin
      csum_r <= 8'h00;
    end else if (start_s && (state_r == ST_IDLE || state_r == ST_ERR)) begin
      csum_r <= 8'h00;
    end else if (state_r == ST_DATA && byte_valid) begin
      csum_r <= csum_update(csum_r, byte_data);
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

  // Protocol state and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      len_lo_r   <= 8'h00;
      len_r      <= 16'h0000;
      byte_idx_r <= {BYTE_IDX_W{1'b0}};
      word_idx_r <= {WIDX_W{1'b0}};
      wdata_r    <= 32'h0;
      addr_r     <= BASE_ADDR;
      wmem_r     <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      cpu_run_r  <= 1'b0;
    end else begin
      state_r    <= state_nx;
      len_lo_r   <= len_lo_nx;
      len_r      <= len_nx;
      byte_idx_r <= byte_idx_nx;
      word_idx_r <= word_idx_nx;
      wdata_r    <= wdata_nx;
      addr_r     <= addr_nx;
      wmem_r     <= wmem_nx;
      busy_r     <= busy_nx;
      err_r      <= err_nx;
      cpu_run_r  <= cpu_run_nx;
    end
  end

  // Frame parsing, word assembly and write generation
  always_comb begin
    state_nx    = state_r;
    len_lo_nx   = len_lo_r;
    len_nx      = len_r;
    byte_idx_nx = byte_idx_r;
    word_idx_nx = word_idx_r;
    wdata_nx    = wdata_r;
    addr_nx     = addr_r;
    wmem_nx     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nx = ST_LEN0;
        else         state_nx = ST_IDLE;
      end
      ST_LEN0: begin
        if (frame_err) begin
          state_nx = ST_ERR;
        end else if (byte_valid) begin
          len_lo_nx = byte_data;
          state_nx  = ST_LEN1;
        end else begin
          state_nx = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (frame_err) begin
          state_nx = ST_ERR;
        end else if (byte_valid) begin
          len_nx      = len_s;
          byte_idx_nx = {BYTE_IDX_W{1'b0}};
          word_idx_nx = {WIDX_W{1'b0}};
          if (len_s > MAX_LEN)       state_nx = ST_ERR;
          else if (len_s == 16'h0)   state_nx = ST_TAIL;
          else                       state_nx = ST_DATA;
        end else begin
          state_nx = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (frame_err) begin
          state_nx = ST_ERR;
        end else if (byte_valid) begin
          wdata_nx[{byte_idx_r, 3'b000} +: 8] = byte_data;
          byte_idx_nx = byte_idx_r + BYTE_IDX_W'(1);
          if (&byte_idx_r) begin
            wmem_nx     = 1'b1;
            addr_nx     = BASE_ADDR + 32'({word_idx_r, 2'b00});
            word_idx_nx = word_idx_inc_s;
            if (16'(word_idx_inc_s) == len_r) state_nx = ST_TAIL;
            else                              state_nx = ST_DATA;
          end else begin
            state_nx = ST_DATA;
          end
        end else begin
          state_nx = ST_DATA;
        end
      end
      ST_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
        if (frame_err)       state_nx = ST_ERR;
        else if (byte_valid) state_nx = (byte_data == csum_r) ? ST_DONE : ST_ERR;
        else                 state_nx = ST_CSUM;
`else
        state_nx = ST_DONE;
`endif
      end
      ST_DONE: state_nx = ST_DONE;
      ST_ERR: begin
        // a fresh start byte resynchronises and clears the error
        if (start_s) state_nx = ST_LEN0;
        else         state_nx = ST_ERR;
      end
      default: state_nx = ST_IDLE;
    endcase
    busy_nx    = (state_nx == ST_LEN0) || (state_nx == ST_LEN1) ||
                 (state_nx == ST_DATA) || (state_nx == ST_CSUM);
    err_nx     = (state_nx == ST_ERR);
    cpu_run_nx = (state_nx == ST_DONE);
  end

  assign wmem    = wmem_r;
  assign addr    = addr_r;
  assign wdata   = wdata_r;
  assign busy    = busy_r;
  assign err     = err_r;
  assign cpu_run = cpu_run_r;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected writes queued as frames are sent,
// compared against writes captured from the memory port.
module tb_uart_boot_loader;

  localparam int          CPB  = 16;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rxd = 1'b1;
  logic        wmem, busy, err, cpu_run;
  logic [31:0] addr, wdata;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [63:0] e, o;
  logic [7:0]  cs;

  always #5 clk = ~clk;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
    .clk(clk), .resetn(resetn), .rxd(rxd), .wmem(wmem), .addr(addr),
    .wdata(wdata), .busy(busy), .err(err), .cpu_run(cpu_run)
  );

  // every cycle with wmem high is one observed write
  always @(negedge clk) if (wmem === 1'b1) obs_q.push_back({addr, wdata});

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_bit;
    tick(CPB);
    rxd = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endtask

  task automatic send_header(input logic [15:0] len);
    send_byte(8'hA5, 1'b1);
    send_byte(len[7:0], 1'b1);
    send_byte(len[15:8], 1'b1);
    cs = 8'h00;
  endtask

  task automatic send_csum(input logic [7:0] c);
`ifdef BOOT_CHECKSUM_EN
    send_byte(c, 1'b1);
`else
    if (c === 8'hxx) rxd = 1'b1;
`endif
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    rxd    = 1'b1;
    tick(3);
    resetn = 1'b1;
    tick(2);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rxd    = 1'b1;
    tick(3);
    n_cmp++;
    if ({wmem, addr, wdata} !== {1'b0, BASE, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_port: got wmem=%b addr=%h wdata=%h, expected 0 %h 0", wmem, addr, wdata, BASE);
    end
    n_cmp++;
    if ({busy, err, cpu_run} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_status: got busy/err/run=%b, expected 000", {busy, err, cpu_run});
    end
    do_reset();
  endtask

  task automatic test_single_word();
    do_reset();
    send_header(16'h0001);
    exp_q.push_back({BASE, 32'h12345678});
    send_word(32'h12345678);
    n_cmp++;
    if (cs !== 8'h08) begin
      n_bad++;
      $display("FAIL single_csum_model: got %h, expected 08", cs);
    end
    send_csum(cs);
    n_cmp++;
    if ({busy, err, cpu_run} !== 3'b001) begin
      n_bad++;
      $display("FAIL single_status: got busy/err/run=%b, expected 001", {busy, err, cpu_run});
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL single_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL single_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_multi_word();
    logic [31:0] words [3];
    words = '{32'h03020100, 32'hA5A5_5A5A, 32'hFFEE_DDCC};
    do_reset();
    send_header(16'h0003);
    n_cmp++;
    if ({busy, err, cpu_run} !== 3'b100) begin
      n_bad++;
      $display("FAIL multi_busy_hdr: got busy/err/run=%b, expected 100", {busy, err, cpu_run});
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({BASE + 32'(4 * i), words[i]});
      send_word(words[i]);
    end
    send_csum(cs);
    n_cmp++;
    if ({busy, err, cpu_run} !== 3'b001) begin
      n_bad++;
      $display("FAIL multi_status: got busy/err/run=%b, expected 001", {busy, err, cpu_run});
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL multi_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL multi_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_garbage();
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    n_cmp++;
    if ({busy, err, cpu_run} !== 3'b000) begin
      n_bad++;
      $display("FAIL garbage_idle: got busy/err/run=%b, expected 000", {busy, err, cpu_run});
    end
    send_header(16'h0001);
    exp_q.push_back({BASE, 32'hDEADBEEF});
    send_word(32'hDEADBEEF);
    send_csum(cs);
    n_cmp++;
    if ({busy, err, cpu_run} !== 3'b001) begin
      n_bad++;
      $display("FAIL garbage_status: got busy/err/run=%b, expected 001", {busy, err, cpu_run});
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL garbage_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL garbage_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_len_limits();
    do_reset();
    send_header(16'h0400);
    n_cmp++;
    if ({busy, err, cpu_run} !== 3'b100) begin
      n_bad++;
      $display("FAIL len_max_ok: got busy/err/run=%b, expected 100", {busy, err, cpu_run});
    end
    do_reset();
    send_header(16'h0401);
    n_cmp++;
    if ({busy, err, cpu_run, obs_q.size() == 0} !== 4'b0101) begin
      n_bad++;
      $display("FAIL len_over_err: got busy/err/run=%b writes=%0d, expected 010 and 0", {busy, err, cpu_run}, obs_q.size());
    end
    send_byte(8'hA5, 1'b1);
    n_cmp++;
    if ({busy, err} !== 2'b10) begin
      n_bad++;
      $display("FAIL len_resync: got busy/err=%b, expected 10", {busy, err});
    end
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    cs = 8'h00;
    exp_q.push_back({BASE, 32'hCAFEF00D});
    send_word(32'hCAFEF00D);
    send_csum(cs);
    n_cmp++;
    if ({busy, err, cpu_run} !== 3'b001) begin
      n_bad++;
      $display("FAIL len_reload_status: got busy/err/run=%b, expected 001", {busy, err, cpu_run});
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL len_reload_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL len_reload_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_len_zero_and_done();
    do_reset();
    send_header(16'h0000);
    send_csum(8'h00);
    n_cmp++;
    if ({busy, err, cpu_run, obs_q.size() == 0} !== 4'b0011) begin
      n_bad++;
      $display("FAIL len_zero: got busy/err/run=%b writes=%0d, expected 001 and 0", {busy, err, cpu_run}, obs_q.size());
    end
    send_header(16'h0001);
    send_word(32'h11223344);
    send_csum(cs);
    n_cmp++;
    if ({busy, err, cpu_run, obs_q.size() == 0} !== 4'b0011) begin
      n_bad++;
      $display("FAIL done_ignores: got busy/err/run=%b writes=%0d, expected 001 and 0", {busy, err, cpu_run}, obs_q.size());
    end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum_bad();
    do_reset();
    send_header(16'h0001);
    exp_q.push_back({BASE, 32'h12345678});
    send_word(32'h12345678);
    send_byte(8'h00, 1'b1);
    n_cmp++;
    if ({busy, err, cpu_run} !== 3'b010) begin
      n_bad++;
      $display("FAIL csum_bad_status: got busy/err/run=%b, expected 010", {busy, err, cpu_run});
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL csum_bad_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL csum_bad_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask
`endif

  task automatic test_framing_err();
    do_reset();
    send_header(16'h0002);
    exp_q.push_back({BASE, 32'h44332211});
    send_word(32'h44332211);
    send_byte(8'h55, 1'b0);
    n_cmp++;
    if ({busy, err, cpu_run} !== 3'b010) begin
      n_bad++;
      $display("FAIL frame_err_status: got busy/err/run=%b, expected 010", {busy, err, cpu_run});
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL frame_err_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL frame_err_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_header(16'h0002);
    exp_q.push_back({BASE, 32'hA1B2C3D4});
    send_word(32'hA1B2C3D4);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    resetn = 1'b0;
    tick(1);
    n_cmp++;
    if ({wmem, addr, wdata, busy, err, cpu_run} !== {1'b0, BASE, 32'h0, 3'b000}) begin
      n_bad++;
      $display("FAIL midreset_outputs: got wmem=%b addr=%h wdata=%h bsy/err/run=%b, expected all reset",
               wmem, addr, wdata, {busy, err, cpu_run});
    end
    resetn = 1'b1;
    tick(2);
    for (int i = 3; i < 9; i++) send_byte(8'(i), 1'b1);
    n_cmp++;
    if ({busy, err, cpu_run} !== 3'b000) begin
      n_bad++;
      $display("FAIL midreset_idle: got busy/err/run=%b, expected 000", {busy, err, cpu_run});
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL midreset_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL midreset_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  initial begin
    cs = 8'h00;
    test_reset();
    test_single_word();
    test_multi_word();
    test_garbage();
    test_len_limits();
    test_len_zero_and_done();
`ifdef BOOT_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_framing_err();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
